// File: rtl/sd_emmc_rx_data_fifo.sv
// sd_emmc_rx_data_fifo: card-to-host word FIFO feeding DMA write data, with edge-triggered pop and paced write indication
module sd_emmc_rx_data_fifo #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int BLK_WORDS = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              fifo_dat_rd_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_dat,
  output logic              is_we_en,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic              underflow,
  output logic              blk_popped
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW = $clog2(BLK_WORDS);
  localparam logic [PW-1:0] LAST = PW'(BLK_WORDS - 1);
  typedef enum logic [1:0] {PULSE_IDLE, PULSE_HIGH, PULSE_LOW} pulse_t;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt, pend, pend_nxt;
  logic [PW-1:0] pop_cnt;
  logic rd_q, pop, pop_ok, wr_ok;
  pulse_t state, state_nxt;
  // a pop frees the slot in the same cycle, so a write while full is accepted alongside it
  always_comb begin
    pop = fifo_dat_rd_ready && !rd_q;
    pop_ok = pop && !fifo_empty && !flush;
    wr_ok = wr_en && !flush && (!fifo_full || pop_ok);
    wr_ptr_nxt = flush ? '0 : wr_ptr + (ADDR_W+1)'(wr_ok);
    rd_ptr_nxt = flush ? '0 : rd_ptr + (ADDR_W+1)'(pop_ok);
    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    pend_nxt = flush ? '0 : pend + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(state == PULSE_HIGH);
    state_nxt = flush ? PULSE_IDLE
              : state == PULSE_HIGH ? PULSE_LOW
              : (pend != '0 || wr_ok) ? PULSE_HIGH : PULSE_IDLE;
  end
  assign is_we_en = state == PULSE_HIGH;
  always_ff @(posedge clock)
    if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= wr_dat;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rd_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pend <= '0;
      state <= PULSE_IDLE;
      fifo_level <= '0;
      fifo_full <= 1'b0;
      fifo_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
      pop_cnt <= '0;
      blk_popped <= 1'b0;
      rd_dat <= '0;
    end else begin
      rd_q <= fifo_dat_rd_ready;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      pend <= pend_nxt;
      state <= state_nxt;
      fifo_level <= level_nxt;
      fifo_full <= level_nxt == (ADDR_W+1)'(DEPTH);
      fifo_empty <= level_nxt == '0;
      overflow <= !flush && (overflow || (wr_en && fifo_full && !pop_ok));
      underflow <= !flush && (underflow || (pop && fifo_empty));
      pop_cnt <= flush ? '0 : !pop_ok ? pop_cnt : pop_cnt == LAST ? '0 : pop_cnt + PW'(1);
      blk_popped <= pop_ok && pop_cnt == LAST;
      // the head slot written this cycle is not yet readable from mem, so forward it
      if (level_nxt != '0)
        rd_dat <= (wr_ok && rd_ptr_nxt == wr_ptr) ? wr_dat : mem[rd_ptr_nxt[ADDR_W-1:0]];
    end
endmodule

// File: tb/tb_sd_emmc_rx_data_fifo.sv
// tb_sd_emmc_rx_data_fifo: scoreboard bench for the receive data FIFO
module tb_sd_emmc_rx_data_fifo;
  logic clock = 0, reset = 0, wr_en = 0, fifo_dat_rd_ready = 0, flush = 0;
  logic [31:0] wr_dat = 0, rd_dat;
  logic is_we_en, fifo_full, fifo_empty, overflow, underflow, blk_popped;
  logic [7:0] fifo_level;
  logic we_q = 0;
  int tests = 0, fails = 0, falls = 0, highs = 0, blks = 0, f0, h0, b0;
  logic [31:0] q[$];

  sd_emmc_rx_data_fifo dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_dat(wr_dat),
    .fifo_dat_rd_ready(fifo_dat_rd_ready), .flush(flush), .rd_dat(rd_dat),
    .is_we_en(is_we_en), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow),
    .blk_popped(blk_popped)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (we_q && !is_we_en) falls++;
    if (is_we_en) highs++;
    if (blk_popped) blks++;
    we_q = is_we_en;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    wr_dat = d;
    wr_en = 1;
    tick();
    wr_en = 0;
    if (q.size() < 128) q.push_back(d);
  endtask

  task automatic pop();
    fifo_dat_rd_ready = 1;
    tick();
    fifo_dat_rd_ready = 0;
    tick();
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
    q.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 128; i++) begin
      pop();
      if (q.size() != 0) check(tag, rd_dat, q[0]);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_rd_dat", rd_dat, 0);
    check("rst_level", fifo_level, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_flags", {overflow, underflow, blk_popped, is_we_en}, 0);
    reset = 1;
    tick();

    f0 = falls; h0 = highs;
    wr(32'hA5A5_0001);
    check("one_rd_dat", rd_dat, 32'hA5A5_0001);
    check("one_level", fifo_level, 1);
    check("one_empty", fifo_empty, 0);
    repeat (5) tick();
    check("one_falls", falls - f0, 1);
    check("one_highs", highs - h0, 1);

    do_flush();
    f0 = falls; h0 = highs;
    for (int i = 1; i <= 4; i++) wr(i);
    check("four_level", fifo_level, 4);
    check("four_head", rd_dat, q[0]);
    repeat (10) tick();
    check("four_falls", falls - f0, 4);
    check("four_highs", highs - h0, 4);

    do_flush();
    b0 = blks;
    for (int i = 0; i < 128; i++) wr(i);
    check("fill_full", fifo_full, 1);
    check("fill_level", fifo_level, 128);
    check("fill_ovf0", overflow, 0);
    check("fill_head", rd_dat, 0);
    wr(32'hDEAD);
    tick();
    check("ovf_flag", overflow, 1);
    check("ovf_level", fifo_level, 128);
    drain("drain_order");
    check("drain_empty", fifo_empty, 1);
    check("drain_level", fifo_level, 0);
    check("drain_blk", blks - b0, 1);

    do_flush();
    check("flush_ovf", overflow, 0);
    wr(32'h11); wr(32'h22); wr(32'h33);
    fifo_dat_rd_ready = 1;
    repeat (5) tick();
    fifo_dat_rd_ready = 0;
    tick();
    void'(q.pop_front());
    check("hold_level", fifo_level, 2);
    check("hold_head", rd_dat, q[0]);

    do_flush();
    for (int i = 0; i < 128; i++) wr(32'h1000 + i);
    wr_dat = 32'h55;
    wr_en = 1;
    fifo_dat_rd_ready = 1;
    tick();
    wr_en = 0;
    fifo_dat_rd_ready = 0;
    void'(q.pop_front());
    q.push_back(32'h55);
    tick();
    check("fullpw_level", fifo_level, 128);
    check("fullpw_ovf", overflow, 0);
    check("fullpw_full", fifo_full, 1);
    check("fullpw_head", rd_dat, q[0]);
    drain("fullpw_order");
    check("fullpw_empty", fifo_empty, 1);

    do_flush();
    repeat (4) tick();
    h0 = highs;
    for (int i = 0; i < 6; i++) wr(32'h200 + i);
    repeat (2) tick();
    flush = 1;
    wr_en = 1;
    wr_dat = 32'hBAD;
    tick();
    flush = 0;
    wr_en = 0;
    q.delete();
    check("mid_we_low", is_we_en, 0);
    check("mid_partial", (highs - h0) < 6, 1);
    h0 = highs;
    repeat (12) tick();
    check("mid_no_pulse", highs - h0, 0);
    check("mid_level", fifo_level, 0);
    check("mid_empty", fifo_empty, 1);
    pop();
    check("udf_flag", underflow, 1);
    check("udf_level", fifo_level, 0);
    do_flush();
    check("udf_clear", underflow, 0);

    wr(32'h77); wr(32'h78);
    #2 reset = 0;
    #1;
    check("arst_level", fifo_level, 0);
    check("arst_empty", fifo_empty, 1);
    check("arst_we", is_we_en, 0);
    check("arst_rd_dat", rd_dat, 0);
    tick();
    reset = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_emmc_rx_data_fifo.md
Name: sd_emmc_rx_data_fifo

Overview:
- Receive-path word buffer between the data-serial host engine (card→host) and the DMA engine (host memory writer).
- Stores 32-bit words from the data-serial engine and presents the head word to the DMA as M_AXI write data.
- Pops one word per rising edge of the DMA's fifo_dat_rd_ready.
- Emits a paced is_we_en pulse train so the DMA can count stored words by falling edges.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 7, log2 depth (128 words = one 512-byte block).
- BLK_WORDS, 128, words per block for blk_popped pulse.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  data-serial write strobe, one word per high cycle.
- wr_dat  in  DATA_W  write data.
- fifo_dat_rd_ready  in  1  DMA pop request; rising edge = one pop.
- flush  in  1  synchronous clear of contents, pointers and pacer (e.g. on dat_int_rst / abort).
- rd_dat  out  DATA_W  head word (first-word-fall-through), to M_AXI wdata.
- is_we_en  out  1  paced write-indication pulses to DMA.
- fifo_full  out  1  level == depth.
- fifo_empty  out  1  level == 0.
- fifo_level  out  ADDR_W+1  current occupancy.
- overflow  out  1  sticky: write while full.
- underflow  out  1  sticky: pop while empty.
- blk_popped  out  1  one-cycle pulse when BLK_WORDS words have been popped since reset/flush/last pulse.

Behaviour:
- Reset: all outputs 0 except fifo_empty=1; rd_dat=0; pointers, pacer and pop-edge flop cleared.
- Storage: 2^ADDR_W x DATA_W array; wr_ptr/rd_ptr ADDR_W+1 bits, wrap modulo 2^(ADDR_W+1). full when MSBs differ and lower bits equal.
- Write: wr_en && !fifo_full stores wr_dat at wr_ptr, wr_ptr+1. wr_en while full: word dropped, overflow<=1.
- Pop detect: rd_q registers fifo_dat_rd_ready; pop = fifo_dat_rd_ready && !rd_q. A level held high for N cycles = one pop.
- Pop: pop && !fifo_empty advances rd_ptr. pop while empty: no pointer change, underflow<=1.
- rd_dat: registered head word.
  - Updates the cycle after any pointer change.
  - When the FIFO goes from empty to non-empty, the written word appears one cycle after the write.
  - Holds its value while empty.
- Simultaneous write+pop: both occur; level unchanged. When full, pop+write is legal and not overflow, since the pop frees the slot that cycle.
- fifo_level, fifo_full, fifo_empty: registered, valid the cycle after the causing event.
- is_we_en pacer: the DMA counts falling edges, so consecutive writes must not merge.
  - pend counter (ADDR_W+1 bits) increments per accepted write.
  - FSM PULSE_IDLE → PULSE_HIGH (is_we_en=1, pend-1) → PULSE_LOW (is_we_en=0) → PULSE_HIGH if pend>0, else PULSE_IDLE.
  - Max one indication per 2 cycles; the increment and decrement of pend in the same cycle net to zero.
- blk_popped: pop counter 0..BLK_WORDS-1. When the counter wraps on a successful pop, blk_popped=1 for one cycle.
- flush:
  - Clears pointers, pend, pop counter and sticky flags.
  - Forces FSM to PULSE_IDLE and is_we_en=0 the next cycle.
  - A wr_en in the same cycle as flush is discarded.
  - flush has priority over all other events.
- Asynchronous reset mid-operation: immediate return to reset values, no pulse completion.

Test Plan:
- Reset, then 1 write of 0xA5A5_0001 → next cycle rd_dat=0xA5A50001, fifo_level=1, fifo_empty=0. is_we_en shows exactly one 1-cycle high pulse.
- 4 back-to-back writes (0x1..0x4), no pops → fifo_level=4. is_we_en toggles H,L,H,L,H,L,H,L: exactly 4 falling edges over 8 cycles.
- Fill 128 words, then write 0xDEAD → fifo_full=1, overflow=1, level stays 128. Then 128 pop edges drain 0..127 in order → fifo_empty=1, blk_popped pulses once on the 128th pop.
- fifo_dat_rd_ready held high 5 cycles with 3 words stored → exactly 1 pop, level=2, rd_dat=second word.
- Full FIFO, write 0x55 and pop edge in same cycle → level stays 128, overflow stays 0, 0x55 appears as the last word.
- Mid-pulse-train: 6 writes, then flush on cycle 3 → is_we_en=0 next cycle, no further pulses, level=0, fifo_empty=1. Pop while empty → underflow=1.
